// File: rtl/mmio_port_responder_if.sv
// Data-memory-side bus seen by the MMIO responder: address/strobes/data in,
// load data and window-hit indication out.
interface mmio_port_responder_if;
    logic [31:0] Address;
    logic        MemWrite;
    logic        MemRead;
    logic [31:0] WriteData;
    logic [31:0] ReadData;
    logic        Hit;

    modport master (
        output Address,
        output MemWrite,
        output MemRead,
        output WriteData,
        input  ReadData,
        input  Hit
    );

    modport slave (
        input  Address,
        input  MemWrite,
        input  MemRead,
        input  WriteData,
        output ReadData,
        output Hit
    );
endinterface

// File: rtl/mmio_port_responder.sv
// Memory-mapped I/O responder: output port, synchronized input port with
// rising-edge capture, and a reloadable down-counter timer with sticky expiry.
module mmio_port_responder #(
    parameter logic [31:0] IO_BASE     = 32'h1001_0100,
    parameter int          TIMER_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    mmio_port_responder_if.slave bus,
    input  logic [7:0]           PortIn,
    output logic [31:0]          PortOut
);

    localparam logic [3:0] OFF_PORT_OUT = 4'h0;
    localparam logic [3:0] OFF_PORT_IN  = 4'h1;
    localparam logic [3:0] OFF_EDGE     = 4'h2;
    localparam logic [3:0] OFF_TLOAD    = 4'h3;
    localparam logic [3:0] OFF_TCOUNT   = 4'h4;
    localparam logic [3:0] OFF_CTRL     = 4'h5;

    logic [31:0]            port_out_q, port_out_d;
    logic [7:0]             s1_q, s2_q, s3_q;
    logic [7:0]             edge_q, edge_d;
    logic [TIMER_WIDTH-1:0] tload_q, tload_d;
    logic [TIMER_WIDTH-1:0] tcount_q, tcount_d;
    logic                   en_q, en_d;
    logic                   exp_q, exp_d;

    logic                   hit;
    logic [3:0]             offset;
    logic                   wr_en;
    logic                   rd_side_en;
    logic                   edge_clear;
    logic [7:0]             edge_rise;
    logic                   exp_set;
    logic [31:0]            rd_data;
    logic                   unused_addr_bits;

    assign hit        = (bus.Address[31:6] == IO_BASE[31:6]);
    assign offset     = bus.Address[5:2];
    assign wr_en      = bus.MemWrite & hit;
    // A simultaneous store takes precedence, so the load's side effect is dropped.
    assign rd_side_en = bus.MemRead & hit & ~bus.MemWrite;
    assign edge_clear = rd_side_en && (offset == OFF_EDGE);
    assign unused_addr_bits = &{1'b0, bus.Address[1:0]};

    // Per-bit edge capture: a rise in the clearing cycle survives the clear.
    for (genvar gi = 0; gi < 8; gi++) begin : g_edge
        assign edge_rise[gi] = s2_q[gi] & ~s3_q[gi];
        assign edge_d[gi]    = (edge_clear ? 1'b0 : edge_q[gi]) | edge_rise[gi];
    end

    always_comb begin
        port_out_d = port_out_q;
        if (wr_en && (offset == OFF_PORT_OUT)) begin
            port_out_d = bus.WriteData;
        end
    end

    always_comb begin
        tload_d  = tload_q;
        tcount_d = tcount_q;
        exp_set  = 1'b0;
        if (wr_en && (offset == OFF_TLOAD)) begin
            tload_d  = bus.WriteData[TIMER_WIDTH-1:0];
            tcount_d = bus.WriteData[TIMER_WIDTH-1:0];
        end else if (en_q) begin
            if (tcount_q != '0) begin
                tcount_d = tcount_q - TIMER_WIDTH'(1);
            end else begin
                tcount_d = tload_q;
                exp_set  = 1'b1;
            end
        end
    end

    always_comb begin
        en_d  = en_q;
        exp_d = exp_q;
        if (wr_en && (offset == OFF_CTRL)) begin
            en_d = bus.WriteData[0];
            if (bus.WriteData[1]) begin
                exp_d = 1'b0;
            end
        end
        if (exp_set) begin
            exp_d = 1'b1;
        end
    end

    always_comb begin
        rd_data = '0;
        if (hit) begin
            case (offset)
                OFF_PORT_OUT: rd_data = port_out_q;
                OFF_PORT_IN:  rd_data[7:0] = s2_q;
                OFF_EDGE:     rd_data[7:0] = edge_q;
                OFF_TLOAD:    rd_data[TIMER_WIDTH-1:0] = tload_q;
                OFF_TCOUNT:   rd_data[TIMER_WIDTH-1:0] = tcount_q;
                OFF_CTRL:     rd_data[1:0] = {exp_q, en_q};
                default:      rd_data = '0;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            port_out_q <= '0;
            s1_q       <= '0;
            s2_q       <= '0;
            s3_q       <= '0;
            edge_q     <= '0;
            tload_q    <= '0;
            tcount_q   <= '0;
            en_q       <= 1'b0;
            exp_q      <= 1'b0;
        end else begin
            port_out_q <= port_out_d;
            s1_q       <= PortIn;
            s2_q       <= s1_q;
            s3_q       <= s2_q;
            edge_q     <= edge_d;
            tload_q    <= tload_d;
            tcount_q   <= tcount_d;
            en_q       <= en_d;
            exp_q      <= exp_d;
        end
    end

    assign bus.ReadData = rd_data;
    assign bus.Hit      = hit;
    assign PortOut      = port_out_q;

endmodule

// File: tb/tb_mmio_port_responder.sv
// Directed-vector bench for mmio_port_responder: one task per feature,
// inline comparisons against hand-computed values.
module tb_mmio_port_responder;

    localparam logic [31:0] IO_BASE  = 32'h1001_0100;
    localparam logic [31:0] A_PORT_OUT = IO_BASE + 32'h00;
    localparam logic [31:0] A_PORT_IN  = IO_BASE + 32'h04;
    localparam logic [31:0] A_EDGE     = IO_BASE + 32'h08;
    localparam logic [31:0] A_TLOAD    = IO_BASE + 32'h0C;
    localparam logic [31:0] A_TCOUNT   = IO_BASE + 32'h10;
    localparam logic [31:0] A_CTRL     = IO_BASE + 32'h14;
    localparam logic [31:0] A_UNMAPPED = IO_BASE + 32'h1C;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  PortIn;
    logic [31:0] PortOut;
    int          checks = 0;
    int          errors = 0;

    mmio_port_responder_if bus ();

    mmio_port_responder #(
        .IO_BASE     (IO_BASE),
        .TIMER_WIDTH (32)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .PortIn  (PortIn),
        .PortOut (PortOut)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog expired");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.Address   = 32'h0;
        bus.MemWrite  = 1'b0;
        bus.MemRead   = 1'b0;
        bus.WriteData = 32'h0;
    endtask

    task automatic do_write(input logic [31:0] a, input logic [31:0] d);
        bus.Address   = a;
        bus.WriteData = d;
        bus.MemWrite  = 1'b1;
        bus.MemRead   = 1'b0;
        tick();
        idle();
        $display("write addr=%h data=%h", a, d);
    endtask

    task automatic do_read(input logic [31:0] a, output logic [31:0] d);
        bus.Address  = a;
        bus.MemRead  = 1'b1;
        bus.MemWrite = 1'b0;
        #1;
        d = bus.ReadData;
        tick();
        idle();
        $display("read  addr=%h data=%h", a, d);
    endtask

    task automatic peek(input logic [31:0] a, output logic [31:0] d);
        bus.Address  = a;
        bus.MemRead  = 1'b0;
        bus.MemWrite = 1'b0;
        #1;
        d = bus.ReadData;
        idle();
    endtask

    task automatic test_reset();
        logic [31:0] d;
        reset = 1'b1;
        PortIn = 8'h00;
        idle();
        tick();
        tick();
        checks++;
        if (PortOut !== 32'h0) begin
            $display("FAIL reset_portout got=%h expected=%h", PortOut, 32'h0);
            errors++;
        end
        reset = 1'b0;
        for (int i = 0; i < 16; i++) begin
            peek(IO_BASE + 32'(i * 4), d);
            checks++;
            if (d !== 32'h0) begin
                $display("FAIL reset_read off=%0h got=%h expected=%h", i * 4, d, 32'h0);
                errors++;
            end
        end
        $display("reset checked, all offsets read");
    endtask

    task automatic test_port_out();
        logic [31:0] d;
        bus.Address   = A_PORT_OUT;
        bus.WriteData = 32'hA5A5_0001;
        bus.MemWrite  = 1'b1;
        #1;
        checks++;
        if (bus.Hit !== 1'b1) begin
            $display("FAIL port_out_hit got=%b expected=1", bus.Hit);
            errors++;
        end
        checks++;
        if (PortOut !== 32'h0) begin
            $display("FAIL port_out_before_edge got=%h expected=%h", PortOut, 32'h0);
            errors++;
        end
        tick();
        idle();
        checks++;
        if (PortOut !== 32'hA5A5_0001) begin
            $display("FAIL port_out_write got=%h expected=%h", PortOut, 32'hA5A5_0001);
            errors++;
        end
        bus.Address   = IO_BASE + 32'h200;
        bus.WriteData = 32'hDEAD_BEEF;
        bus.MemWrite  = 1'b1;
        #1;
        checks++;
        if (bus.Hit !== 1'b0 || bus.ReadData !== 32'h0) begin
            $display("FAIL miss_decode got hit=%b rd=%h expected hit=0 rd=0", bus.Hit, bus.ReadData);
            errors++;
        end
        tick();
        idle();
        checks++;
        if (PortOut !== 32'hA5A5_0001) begin
            $display("FAIL miss_write got=%h expected=%h", PortOut, 32'hA5A5_0001);
            errors++;
        end
        do_write(A_PORT_OUT + 32'h3, 32'h0BAD_F00D);
        peek(A_PORT_OUT, d);
        checks++;
        if (d !== 32'h0BAD_F00D || PortOut !== 32'h0BAD_F00D) begin
            $display("FAIL port_out_low_bits got rd=%h out=%h expected=%h", d, PortOut, 32'h0BAD_F00D);
            errors++;
        end
    endtask

    task automatic test_port_in_edge();
        logic [31:0] d;
        PortIn = 8'h81;
        tick();
        peek(A_PORT_IN, d);
        checks++;
        if (d !== 32'h00) begin
            $display("FAIL port_in_k got=%h expected=%h", d, 32'h00);
            errors++;
        end
        tick();
        peek(A_PORT_IN, d);
        checks++;
        if (d !== 32'h81) begin
            $display("FAIL port_in_k1 got=%h expected=%h", d, 32'h81);
            errors++;
        end
        peek(A_EDGE, d);
        checks++;
        if (d !== 32'h00) begin
            $display("FAIL edge_k1 got=%h expected=%h", d, 32'h00);
            errors++;
        end
        tick();
        peek(A_EDGE, d);
        checks++;
        if (d !== 32'h81) begin
            $display("FAIL edge_k2 got=%h expected=%h", d, 32'h81);
            errors++;
        end
        do_read(A_EDGE, d);
        checks++;
        if (d !== 32'h81) begin
            $display("FAIL edge_read got=%h expected=%h", d, 32'h81);
            errors++;
        end
        do_read(A_EDGE, d);
        checks++;
        if (d !== 32'h00) begin
            $display("FAIL edge_cleared got=%h expected=%h", d, 32'h00);
            errors++;
        end
    endtask

    task automatic test_edge_set_wins();
        logic [31:0] d;
        PortIn = 8'h00;
        repeat (3) tick();
        PortIn = 8'h01;
        repeat (3) tick();
        peek(A_EDGE, d);
        checks++;
        if (d !== 32'h01) begin
            $display("FAIL edge_bit0 got=%h expected=%h", d, 32'h01);
            errors++;
        end
        PortIn = 8'h09;
        tick();
        tick();
        do_read(A_EDGE, d);
        checks++;
        if (d !== 32'h01) begin
            $display("FAIL edge_clear_read got=%h expected=%h", d, 32'h01);
            errors++;
        end
        peek(A_EDGE, d);
        checks++;
        if (d !== 32'h08) begin
            $display("FAIL edge_set_wins got=%h expected=%h", d, 32'h08);
            errors++;
        end
    endtask

    task automatic test_timer();
        logic [31:0] d;
        logic [31:0] exp_cnt;
        do_write(A_TLOAD, 32'd3);
        peek(A_TCOUNT, d);
        checks++;
        if (d !== 32'd3) begin
            $display("FAIL tload_loads_tcount got=%h expected=%h", d, 32'd3);
            errors++;
        end
        do_write(A_CTRL, 32'd1);
        for (int i = 0; i < 5; i++) begin
            exp_cnt = 32'((3 - i) & 3);
            peek(A_TCOUNT, d);
            checks++;
            if (d !== exp_cnt) begin
                $display("FAIL tcount_seq step=%0d got=%h expected=%h", i, d, exp_cnt);
                errors++;
            end
            if (i == 3) begin
                peek(A_CTRL, d);
                checks++;
                if (d !== 32'h1) begin
                    $display("FAIL exp_early got=%h expected=%h", d, 32'h1);
                    errors++;
                end
            end
            if (i < 4) tick();
        end
        peek(A_CTRL, d);
        checks++;
        if (d !== 32'h3) begin
            $display("FAIL exp_set got=%h expected=%h", d, 32'h3);
            errors++;
        end
        do_write(A_CTRL, 32'd3);
        peek(A_CTRL, d);
        checks++;
        if (d !== 32'h1) begin
            $display("FAIL exp_w1c got=%h expected=%h", d, 32'h1);
            errors++;
        end
        peek(A_TCOUNT, d);
        checks++;
        if (d !== 32'd2) begin
            $display("FAIL tcount_after_w1c got=%h expected=%h", d, 32'd2);
            errors++;
        end
    endtask

    task automatic test_exp_set_wins_and_reset();
        logic [31:0] d;
        PortIn = 8'h00;
        tick();
        tick();
        peek(A_TCOUNT, d);
        checks++;
        if (d !== 32'd0) begin
            $display("FAIL tcount_zero got=%h expected=%h", d, 32'd0);
            errors++;
        end
        do_write(A_CTRL, 32'd2);
        peek(A_CTRL, d);
        checks++;
        if (d !== 32'h2) begin
            $display("FAIL exp_set_wins got=%h expected=%h", d, 32'h2);
            errors++;
        end
        peek(A_TCOUNT, d);
        checks++;
        if (d !== 32'd3) begin
            $display("FAIL reload_on_expiry got=%h expected=%h", d, 32'd3);
            errors++;
        end
        tick();
        peek(A_TCOUNT, d);
        checks++;
        if (d !== 32'd3) begin
            $display("FAIL tcount_hold_disabled got=%h expected=%h", d, 32'd3);
            errors++;
        end
        do_write(A_CTRL, 32'd1);
        peek(A_TCOUNT, d);
        checks++;
        if (d !== 32'd3) begin
            $display("FAIL enable_no_reload got=%h expected=%h", d, 32'd3);
            errors++;
        end
        tick();
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if (PortOut !== 32'h0) begin
            $display("FAIL async_reset_portout got=%h expected=%h", PortOut, 32'h0);
            errors++;
        end
        peek(A_TCOUNT, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL async_reset_tcount got=%h expected=%h", d, 32'h0);
            errors++;
        end
        peek(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL async_reset_ctrl got=%h expected=%h", d, 32'h0);
            errors++;
        end
        peek(A_EDGE, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL async_reset_edge got=%h expected=%h", d, 32'h0);
            errors++;
        end
        tick();
        reset = 1'b0;
        tick();
        peek(A_TCOUNT, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL post_reset_tcount got=%h expected=%h", d, 32'h0);
            errors++;
        end
    endtask

    task automatic test_back_to_back_dual_and_unmapped();
        logic [31:0] d;
        do_write(A_PORT_OUT, 32'h0000_1234);
        do_write(A_TLOAD, 32'd5);
        PortIn = 8'h10;
        repeat (3) tick();
        peek(A_EDGE, d);
        checks++;
        if (d !== 32'h10) begin
            $display("FAIL edge_bit4 got=%h expected=%h", d, 32'h10);
            errors++;
        end
        bus.Address   = A_EDGE;
        bus.WriteData = 32'hFF;
        bus.MemWrite  = 1'b1;
        bus.MemRead   = 1'b1;
        #1;
        d = bus.ReadData;
        tick();
        idle();
        checks++;
        if (d !== 32'h10) begin
            $display("FAIL dual_read_data got=%h expected=%h", d, 32'h10);
            errors++;
        end
        peek(A_EDGE, d);
        checks++;
        if (d !== 32'h10) begin
            $display("FAIL dual_no_clear got=%h expected=%h", d, 32'h10);
            errors++;
        end
        do_write(A_UNMAPPED, 32'hFFFF_FFFF);
        do_read(A_UNMAPPED, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL unmapped_read got=%h expected=%h", d, 32'h0);
            errors++;
        end
        peek(A_EDGE, d);
        checks++;
        if (d !== 32'h10) begin
            $display("FAIL unmapped_edge got=%h expected=%h", d, 32'h10);
            errors++;
        end
        checks++;
        if (PortOut !== 32'h0000_1234) begin
            $display("FAIL unmapped_portout got=%h expected=%h", PortOut, 32'h0000_1234);
            errors++;
        end
        peek(A_TLOAD, d);
        checks++;
        if (d !== 32'd5) begin
            $display("FAIL unmapped_tload got=%h expected=%h", d, 32'd5);
            errors++;
        end
        peek(A_CTRL, d);
        checks++;
        if (d !== 32'h0) begin
            $display("FAIL unmapped_ctrl got=%h expected=%h", d, 32'h0);
            errors++;
        end
        peek(A_TCOUNT, d);
        checks++;
        if (d !== 32'd5) begin
            $display("FAIL unmapped_tcount got=%h expected=%h", d, 32'd5);
            errors++;
        end
    endtask

    initial begin
        test_reset();
        test_port_out();
        test_port_in_edge();
        test_edge_set_wins();
        test_timer();
        test_exp_set_wins_and_reset();
        test_back_to_back_dual_and_unmapped();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/mmio_port_responder.md
Name: mmio_port_responder

Overview:
- Memory-mapped I/O responder on the processor's data-memory bus (Address, MemWrite, MemRead, WriteData, ReadData), in parallel with DataMemory.
- Decodes a 64-byte I/O window and drives the processor's PortOut.
- Synchronizes PortIn and latches its rising edges.
- Provides a reloadable down-counter timer with a sticky expiry flag.
- Hit is used at top level to select ReadData from this block instead of DataMemory and to gate DataMemory MemWrite.

Parameters:
- IO_BASE, 32'h1001_0100, byte base address of the I/O window; bits [5:0] must be zero.
- TIMER_WIDTH, 32, width of the timer load and count registers (1..32).

Ports:
- clk  input  1  system clock, rising edge.
- reset  input  1  asynchronous, active-high reset.
- Address  input  32  byte address from the EX/MEM stage ALU result.
- MemWrite  input  1  store strobe, one cycle per store.
- MemRead  input  1  load strobe, one cycle per load.
- WriteData  input  32  store data.
- PortIn  input  8  external asynchronous input pins.
- ReadData  output  32  load data; combinational, valid in the same cycle as MemRead.
- Hit  output  1  combinational; 1 when Address[31:6] == IO_BASE[31:6].
- PortOut  output  32  registered output port.

Behaviour:
- Reset (async, active-high): PortOut, the sync stages s1/s2/s3, EDGE, TLOAD, TCOUNT, EN and EXP all clear to 0. ReadData follows its decode and is 0 when Hit=0.
- Decode:
  - Hit = Address[31:6] == IO_BASE[31:6].
  - Register offset = Address[5:2]; Address[1:0] are ignored.
  - Write effect = MemWrite & Hit, applied at the clock edge.
  - Read side effect = MemRead & Hit, applied at the clock edge.
  - MemWrite and MemRead both high in one cycle: write is applied, read side effect is suppressed.
- Register map (word offsets):
  - 0x00 PORT_OUT, RW, 32 bits. A write updates PortOut at the next edge.
  - 0x04 PORT_IN, RO. ReadData = {24'b0, s2}.
  - 0x08 EDGE, RO, clear-on-read. Bit i sets when s2[i] & ~s3[i].
  - 0x0C TLOAD, RW. A write loads both TLOAD and TCOUNT with WriteData[TIMER_WIDTH-1:0]. Reads are zero-extended.
  - 0x10 TCOUNT, RO, zero-extended.
  - 0x14 CTRL: bit0 EN (RW); bit1 EXP (read; write 1 clears it); other bits read 0.
  - Offsets 0x18–0x3C read 0; writes to them are ignored.
- Synchronizer: s1 <= PortIn, s2 <= s1, s3 <= s2.
  - A PortIn change before edge k is readable in PORT_IN after edge k+1.
  - The matching EDGE bit sets at edge k+2.
- EDGE update per bit: next = (read_clear ? 0 : EDGE) | rise. A rising edge arriving in the same cycle as a clear-on-read is kept (set wins).
- Timer, each edge:
  - Write to TLOAD has priority: TCOUNT <= data.
  - Else, if EN and TCOUNT != 0: TCOUNT <= TCOUNT - 1.
  - Else, if EN and TCOUNT == 0: TCOUNT <= TLOAD and EXP <= 1.
  - With EN=0, TCOUNT holds.
  - Expiry period = TLOAD + 1 cycles. TLOAD = 0 with EN = 1 sets EXP every cycle.
  - Enabling EN does not reload TCOUNT.
  - No wrap below zero.
- EXP: set wins over a same-cycle W1C. Writing CTRL with bit1 = 0 leaves EXP unchanged.
- Reset mid-operation: all state clears immediately. No stale EDGE or EXP survives reset.

Test Plan:
1. Reset → PortOut = 0, reads of every offset = 0. Store 0xA5A5_0001 to IO_BASE+0x00 → PortOut = 0xA5A5_0001 after one edge. Store to IO_BASE+0x200 → Hit = 0, PortOut unchanged.
2. PortIn 0x00→0x81 before edge k → PORT_IN reads 0x81 from edge k+1, EDGE reads 0x81 from edge k+2. A load of EDGE at edge k+3 returns 0x81, and the next read returns 0x00.
3. Clear-on-read of EDGE while PortIn[3] rises into s2 in the same cycle → next EDGE read = 0x08.
4. Write TLOAD = 3, then CTRL = 1 → TCOUNT reads 3, 2, 1, 0, then reloads to 3 with EXP = 1; period 4 cycles. Write CTRL = 3 → EXP clears, EN stays 1.
5. Write CTRL = 2 in the exact cycle TCOUNT hits 0 → EXP stays 1. Assert reset mid-count → TCOUNT = 0, EN = 0, EXP = 0 immediately.
6. MemWrite and MemRead both high on EDGE offset → EDGE not cleared. Access offset 0x1C → read 0, no state change.
